// File: rtl/tl_ram_if.sv
// rtl/tl_ram_if.sv - TL-UL channel A/D signal bundle between one master and the tl_ram responder
//
// Ports (signals of the bundle; clk/rst are plain ports of the modules):
//   a_opcode[2:0]   master->slave  0 PutFullData, 1 PutPartialData, 4 Get
//   a_param[2:0]    master->slave  reserved
//   a_size[2:0]     master->slave  log2 of transfer bytes
//   a_source        master->slave  master ID, echoed on d_source
//   a_address[31:0] master->slave  byte address within the block
//   a_mask[3:0]     master->slave  byte-lane enables
//   a_data[31:0]    master->slave  write data
//   a_corrupt       master->slave  write beat corrupt
//   a_valid         master->slave  channel A valid
//   a_ready         slave->master  channel A ready
//   d_opcode[2:0]   slave->master  0 AccessAck, 1 AccessAckData
//   d_param[1:0]    slave->master  always 0
//   d_size[2:0]     slave->master  echo of a_size
//   d_source        slave->master  echo of a_source
//   d_sink          slave->master  always 0
//   d_denied        slave->master  request rejected
//   d_data[31:0]    slave->master  read data
//   d_corrupt       slave->master  response data invalid
//   d_valid         slave->master  channel D valid
//   d_ready         master->slave  channel D ready

interface tl_ram_if;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic        a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        a_valid;
    logic        a_ready;

    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic        d_source;
    logic        d_sink;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;
    logic        d_valid;
    logic        d_ready;

    modport master (
        output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
        input  a_ready,
        input  d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid,
        output d_ready
    );

    modport slave (
        input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
        output a_ready,
        output d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid,
        input  d_ready
    );
endinterface

// File: rtl/tl_ram.sv
// rtl/tl_ram.sv - TL-UL responder exposing a word-addressed 32-bit scratchpad RAM
//
// Parameters:
//   DEPTH  number of 32-bit words, power of two, 2 .. 2**29
//   AW     word-index width, derived
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset
//   tl     tl_ram_if.slave, TL-UL channels A (request) and D (response)

module tl_ram #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic     clk,
    input  logic     rst,
    tl_ram_if.slave  tl
);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] D_ACK          = 3'd0;
    localparam logic [2:0] D_ACK_DATA     = 3'd1;

    // Request decode
    logic          is_put;
    logic          is_get;
    logic          out_of_range;
    logic          misaligned;
    logic          size_bad;
    logic          denied;
    logic [AW-1:0] word_idx;

    // Handshake
    logic a_ready;
    logic a_fire;
    logic d_fire;
    logic wr_en;
    logic rd_en;

    // Response register
    logic        d_valid_q;
    logic [2:0]  d_opcode_q;
    logic [2:0]  d_size_q;
    logic        d_source_q;
    logic        d_denied_q;
    logic        d_corrupt_q;
    logic        data_sel_q;

    // Storage
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_q;

    logic unused_a_param;
    assign unused_a_param = ^tl.a_param;

    always_comb begin
        is_put       = (tl.a_opcode == OP_PUT_FULL) || (tl.a_opcode == OP_PUT_PARTIAL);
        is_get       = (tl.a_opcode == OP_GET);
        // Anything above the last word, including high address bits, is outside the block.
        out_of_range = |tl.a_address[31:AW+2];
        word_idx     = tl.a_address[AW+1:2];
        misaligned   = 1'b0;
        size_bad     = 1'b0;
        case (tl.a_size)
            3'd0:    misaligned = 1'b0;
            3'd1:    misaligned = tl.a_address[0];
            3'd2:    misaligned = |tl.a_address[1:0];
            default: size_bad   = 1'b1;
        endcase
        denied = out_of_range | misaligned | size_bad | ~(is_put | is_get) | (is_put & tl.a_corrupt);
    end

    // A is accepted whenever the response slot is empty or drains this cycle,
    // which gives one transfer per cycle while D is not stalled.
    assign a_ready = rst & (~d_valid_q | tl.d_ready);
    assign a_fire  = tl.a_valid & a_ready;
    assign d_fire  = d_valid_q & tl.d_ready;
    assign wr_en   = a_fire & is_put & ~denied;
    assign rd_en   = a_fire & is_get & ~denied;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_valid_q   <= 1'b0;
            d_opcode_q  <= 3'd0;
            d_size_q    <= 3'd0;
            d_source_q  <= 1'b0;
            d_denied_q  <= 1'b0;
            d_corrupt_q <= 1'b0;
            data_sel_q  <= 1'b0;
        end else if (a_fire) begin
            d_valid_q   <= 1'b1;
            d_opcode_q  <= is_put ? D_ACK : D_ACK_DATA;
            d_size_q    <= tl.a_size;
            d_source_q  <= tl.a_source;
            d_denied_q  <= denied;
            // Only data-carrying responses can be corrupt; a denied Put is a plain ack.
            d_corrupt_q <= denied & ~is_put;
            data_sel_q  <= rd_en;
        end else if (d_fire) begin
            d_valid_q   <= 1'b0;
        end
    end

    // RAM array and read register carry no reset so they map onto block RAM.
    // The read register only moves on an accepted Get, so d_data stays stable
    // while D is stalled; data_sel_q forces zero for acks, denials and reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (tl.a_mask[i]) begin
                    mem[word_idx][8*i +: 8] <= tl.a_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem[word_idx];
        end
    end

    assign tl.a_ready   = a_ready;
    assign tl.d_valid   = d_valid_q;
    assign tl.d_opcode  = d_opcode_q;
    assign tl.d_param   = 2'd0;
    assign tl.d_size    = d_size_q;
    assign tl.d_source  = d_source_q;
    assign tl.d_sink    = 1'b0;
    assign tl.d_denied  = d_denied_q;
    assign tl.d_corrupt = d_corrupt_q;
    assign tl.d_data    = data_sel_q ? rd_data_q : 32'd0;

endmodule

// File: tb/tb_tl_ram.sv
// tb/tb_tl_ram.sv - self-checking bench for tl_ram: vector table plus scoreboard and corner sequences

module tb_tl_ram;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    tl_ram_if bus();

    tl_ram #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .tl  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic        src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        cor;
        logic [2:0]  e_op;
        logic        e_den;
        logic        e_cor;
        logic [31:0] e_data;
    } vec_t;

    typedef logic [43:0] resp_t;

    resp_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    last_fire = 0;
    int    first_fire = 0;
    vec_t  tbl[$];

    function automatic vec_t mk(logic [2:0] op, logic [2:0] size, logic src, logic [31:0] addr,
                                logic [3:0] mask, logic [31:0] data, logic cor,
                                logic [2:0] e_op, logic e_den, logic e_cor, logic [31:0] e_data);
        vec_t v;
        v.op = op; v.size = size; v.src = src; v.addr = addr; v.mask = mask; v.data = data;
        v.cor = cor; v.e_op = e_op; v.e_den = e_den; v.e_cor = e_cor; v.e_data = e_data;
        return v;
    endfunction

    // {opcode, param, size, source, sink, denied, corrupt, data}
    function automatic resp_t pack_exp(vec_t v);
        return {v.e_op, 2'b00, v.size, v.src, 1'b0, v.e_den, v.e_cor, v.e_data};
    endfunction

    function automatic resp_t pack_act();
        return {bus.d_opcode, bus.d_param, bus.d_size, bus.d_source, bus.d_sink,
                bus.d_denied, bus.d_corrupt, bus.d_data};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request and hold it until accepted; a_valid is left high so
    // consecutive calls stream back-to-back.
    task automatic send(vec_t v);
        bit done;
        done = 1'b0;
        @(posedge clk);
        #1;
        bus.a_opcode  = v.op;
        bus.a_param   = 3'd0;
        bus.a_size    = v.size;
        bus.a_source  = v.src;
        bus.a_address = v.addr;
        bus.a_mask    = v.mask;
        bus.a_data    = v.data;
        bus.a_corrupt = v.cor;
        bus.a_valid   = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (bus.a_ready) begin
                sb.push_back(pack_exp(v));
                last_fire = cyc;
                done = 1'b1;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: a_ready never seen for addr %h", v.addr);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.d_valid) break;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    // Scoreboard: every D fire pops the oldest expected response.
    always @(negedge clk) begin
        if (rst && bus.d_valid && bus.d_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got %h expected none", pack_act());
            end else begin
                check("resp", pack_act(), sb.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v1;
        vec_t v2;

        bus.a_opcode  = 3'd0;
        bus.a_param   = 3'd0;
        bus.a_size    = 3'd0;
        bus.a_source  = 1'b0;
        bus.a_address = 32'd0;
        bus.a_mask    = 4'd0;
        bus.a_data    = 32'd0;
        bus.a_corrupt = 1'b0;
        bus.a_valid   = 1'b0;
        bus.d_ready   = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_d_valid", bus.d_valid, 0);
        check("reset_a_ready", bus.a_ready, 0);
        check("reset_payload", pack_act(), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("release_a_ready", bus.a_ready, 1);

        //         op  sz src addr         mask     data          cor  e_op den cor e_data
        tbl.push_back(mk(0, 2, 1, 32'h4,      4'hF,    32'hDEADBEEF, 0,   0, 0, 0, 32'h0));
        tbl.push_back(mk(4, 2, 0, 32'h4,      4'h0,    32'h0,        0,   1, 0, 0, 32'hDEADBEEF));
        tbl.push_back(mk(1, 2, 1, 32'h4,      4'b0010, 32'h00005500, 0,   0, 0, 0, 32'h0));
        tbl.push_back(mk(4, 2, 1, 32'h4,      4'hF,    32'h0,        0,   1, 0, 0, 32'hDEAD55EF));
        tbl.push_back(mk(4, 2, 0, DEPTH*4,    4'hF,    32'h0,        0,   1, 1, 1, 32'h0));
        tbl.push_back(mk(0, 2, 0, 32'h6,      4'hF,    32'h12345678, 0,   0, 1, 0, 32'h0));
        tbl.push_back(mk(4, 2, 0, 32'h4,      4'hF,    32'h0,        0,   1, 0, 0, 32'hDEAD55EF));
        tbl.push_back(mk(0, 2, 1, 32'h4,      4'hF,    32'h0BADF00D, 1,   0, 1, 0, 32'h0));
        tbl.push_back(mk(4, 2, 0, 32'h4,      4'hF,    32'h0,        0,   1, 0, 0, 32'hDEAD55EF));
        tbl.push_back(mk(2, 2, 0, 32'h8,      4'hF,    32'h0,        0,   1, 1, 1, 32'h0));
        tbl.push_back(mk(4, 3, 0, 32'h8,      4'hF,    32'h0,        0,   1, 1, 1, 32'h0));
        tbl.push_back(mk(0, 2, 0, 32'h8,      4'hF,    32'h11223344, 0,   0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 1, 32'hA,      4'b1100, 32'hABCD0000, 0,   0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h9,      4'b0110, 32'hFFFFFFFF, 0,   0, 1, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'hB,      4'b1000, 32'h77000000, 0,   0, 0, 0, 32'h0));
        tbl.push_back(mk(4, 0, 1, 32'hB,      4'b1000, 32'h0,        0,   1, 0, 0, 32'h77CD3344));
        tbl.push_back(mk(0, 2, 0, DEPTH*4-4,  4'hF,    32'hCAFEF00D, 0,   0, 0, 0, 32'h0));
        tbl.push_back(mk(4, 2, 1, DEPTH*4-4,  4'hF,    32'h0,        0,   1, 0, 0, 32'hCAFEF00D));
        tbl.push_back(mk(4, 2, 0, 32'h80000004, 4'hF,  32'h0,        0,   1, 1, 1, 32'h0));
        tbl.push_back(mk(1, 2, 0, 32'h4,      4'b0101, 32'h00AA00BB, 0,   0, 0, 0, 32'h0));
        tbl.push_back(mk(4, 2, 0, 32'h4,      4'hF,    32'h0,        0,   1, 0, 0, 32'hDEAA55BB));
        tbl.push_back(mk(4, 1, 1, 32'h6,      4'hF,    32'h0,        0,   1, 0, 0, 32'hDEAA55BB));

        foreach (tbl[i]) send(tbl[i]);
        idle();
        drain();

        // Back-pressure: first Get stalls 3 cycles, second is queued behind it
        v1 = mk(4, 2, 1, 32'h8, 4'hF, 32'h0, 0, 1, 0, 0, 32'h77CD3344);
        v2 = mk(4, 2, 0, DEPTH*4-4, 4'hF, 32'h0, 0, 1, 0, 0, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        bus.d_ready = 1'b0;
        send(v1);
        @(posedge clk);
        #1;
        bus.a_opcode  = v2.op;
        bus.a_size    = v2.size;
        bus.a_source  = v2.src;
        bus.a_address = v2.addr;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_d_valid", bus.d_valid, 1);
            check("stall_a_ready", bus.a_ready, 0);
            check("stall_payload", pack_act(), pack_exp(v1));
        end
        @(posedge clk);
        #1;
        bus.d_ready = 1'b1;
        @(negedge clk);
        check("unstall_a_ready", bus.a_ready, 1);
        sb.push_back(pack_exp(v2));
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
        @(negedge clk);
        check("replace_d_valid", bus.d_valid, 1);
        @(negedge clk);
        check("dfire_only_d_valid", bus.d_valid, 0);
        drain();

        // Streaming: four Puts then four Gets, one transfer per cycle
        for (int i = 0; i < 4; i++) begin
            send(mk(0, 2, i[0], 32'(4*i), 4'hF, 32'hA5000000 | 32'(i * 17), 0, 0, 0, 0, 32'h0));
            if (i == 0) first_fire = last_fire;
        end
        for (int i = 0; i < 4; i++) begin
            send(mk(4, 2, i[0], 32'(4*i), 4'hF, 32'h0, 0, 1, 0, 0, 32'hA5000000 | 32'(i * 17)));
        end
        idle();
        check("stream_cycles", last_fire - first_fire, 7);
        drain();

        // Reset in the middle of a stalled Put response
        @(posedge clk);
        #1;
        bus.d_ready = 1'b0;
        send(mk(0, 2, 0, 32'h10, 4'hF, 32'h5A5AA5A5, 0, 0, 0, 0, 32'h0));
        idle();
        @(negedge clk);
        check("pre_reset_d_valid", bus.d_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_d_valid", bus.d_valid, 0);
        check("async_reset_a_ready", bus.a_ready, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        bus.d_ready = 1'b1;
        send(mk(4, 2, 1, 32'h10, 4'hF, 32'h0, 0, 1, 0, 0, 32'h5A5AA5A5));
        idle();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
